// File: rtl/uart_tx_fifo_if.sv
// Host-side bundle for the buffered UART transmitter: write port, status and serial line.
// Defining UART_TX_FIFO_CTS_EN adds the cts_i clear-to-send input.
interface uart_tx_fifo_if #(
  parameter int unsigned CLOCK_DIVIDER_WIDTH = 16,
  parameter int unsigned DATA_WIDTH          = 8,
  parameter int unsigned FIFO_DEPTH_LOG2     = 4
);
  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i;
  logic [DATA_WIDTH-1:0]          data_i;
  logic                           write_i;
  logic                           two_stop_bits_i;
  logic                           parity_bit_i;
  logic                           parity_even_i;
  logic                           full_o;
  logic                           empty_o;
  logic [FIFO_DEPTH_LOG2:0]       level_o;
  logic                           overflow_o;
  logic                           busy_o;
  logic                           serial_o;
`ifdef UART_TX_FIFO_CTS_EN
  logic                           cts_i;
`endif

  modport master (
`ifdef UART_TX_FIFO_CTS_EN
    output cts_i,
`endif
    output clock_divider_i, data_i, write_i, two_stop_bits_i, parity_bit_i, parity_even_i,
    input  full_o, empty_o, level_o, overflow_o, busy_o, serial_o
  );

  modport slave (
`ifdef UART_TX_FIFO_CTS_EN
    input  cts_i,
`endif
    input  clock_divider_i, data_i, write_i, two_stop_bits_i, parity_bit_i, parity_even_i,
    output full_o, empty_o, level_o, overflow_o, busy_o, serial_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: character FIFO with per-character framing feeding a frame shifter.
// Optional feature: define UART_TX_FIFO_CTS_EN for a synchronised clear-to-send gate (bus.cts_i).
module uart_tx_fifo #(
  parameter int unsigned CLOCK_DIVIDER_WIDTH = 16,
  parameter int unsigned DATA_WIDTH          = 8,
  parameter int unsigned FIFO_DEPTH_LOG2     = 4
) (
  input  logic          clock_i,
  input  logic          reset_i,
  uart_tx_fifo_if.slave bus
);
  localparam int unsigned Depth   = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned EntryW  = DATA_WIDTH + 3;
  localparam int unsigned FrameW  = DATA_WIDTH + 4;
  localparam int unsigned BitCntW = 4;
  localparam logic [FIFO_DEPTH_LOG2:0] DepthLvl = (FIFO_DEPTH_LOG2 + 1)'(Depth);
  localparam logic [CLOCK_DIVIDER_WIDTH-1:0] One = CLOCK_DIVIDER_WIDTH'(1);

  typedef enum logic [1:0] {StPostReset, StIdle, StSend} state_e;

  logic [EntryW-1:0]              mem_q [Depth];
  logic [FIFO_DEPTH_LOG2-1:0]     wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_LOG2:0]       level_q;
  logic                           overflow_q;
  state_e                         state_q, state_d;
  logic [CLOCK_DIVIDER_WIDTH-1:0] cnt_q, cnt_d, bit_time_q, bit_time_d, div_live;
  logic [BitCntW-1:0]             bits_q, bits_d, head_len;
  logic [FrameW-1:0]              frame_q, frame_d, head_frame;
  logic                           serial_q;
  logic                           full, empty, push, pop, start, cts_ok;
  logic [EntryW-1:0]              head;
  logic [DATA_WIDTH-1:0]          head_data;
  logic                           head_two_stop, head_par_en, head_even;

`ifdef UART_TX_FIFO_CTS_EN
  logic cts_meta_q, cts_sync_q;
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cts_meta_q <= 1'b0;
      cts_sync_q <= 1'b0;
    end else begin
      cts_meta_q <= bus.cts_i;
      cts_sync_q <= cts_meta_q;
    end
  end
  assign cts_ok = cts_sync_q;
`else
  assign cts_ok = 1'b1;
`endif

  assign full     = (level_q == DepthLvl);
  assign empty    = (level_q == '0);
  assign push     = bus.write_i && !full;
  assign div_live = (bus.clock_divider_i == '0) ? One : bus.clock_divider_i;

  assign head          = mem_q[rd_ptr_q];
  assign head_data     = head[DATA_WIDTH-1:0];
  assign head_two_stop = head[DATA_WIDTH];
  assign head_par_en   = head[DATA_WIDTH+1];
  assign head_even     = head[DATA_WIDTH+2];

  // Frame is shifted out from bit 0; the top bits stay 1 and double as stop bits.
  always_comb begin
    head_frame = {3'b111, head_data, 1'b0};
    if (head_par_en) head_frame[DATA_WIDTH+1] = head_even ? ^head_data : ~^head_data;
    head_len = BitCntW'(DATA_WIDTH + 2) + BitCntW'(head_par_en) + BitCntW'(head_two_stop);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bits_d     = bits_q;
    frame_d    = frame_q;
    bit_time_d = bit_time_q;
    start      = 1'b0;
    case (state_q)
      StPostReset: begin
        if (cnt_q >= div_live - One) begin
          cnt_d = '0;
          if (bits_q == '0) state_d = StIdle;
          else              bits_d  = bits_q - 1'b1;
        end else begin
          cnt_d = cnt_q + One;
        end
      end
      StIdle: start = !empty && cts_ok;
      StSend: begin
        if (cnt_q == bit_time_q - One) begin
          cnt_d = '0;
          if (bits_q == '0) begin
            if (!empty && cts_ok) start   = 1'b1;
            else                  state_d = StIdle;
          end else begin
            bits_d  = bits_q - 1'b1;
            frame_d = {1'b1, frame_q[FrameW-1:1]};
          end
        end else begin
          cnt_d = cnt_q + One;
        end
      end
      default: state_d = StIdle;
    endcase
    if (start) begin
      state_d    = StSend;
      cnt_d      = '0;
      bits_d     = head_len - 1'b1;
      frame_d    = head_frame;
      bit_time_d = div_live;
    end
  end

  assign pop = start;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StPostReset;
      cnt_q      <= '0;
      bits_q     <= BitCntW'(DATA_WIDTH + 3);
      frame_q    <= '1;
      bit_time_q <= One;
      serial_q   <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bits_q     <= bits_d;
      frame_q    <= frame_d;
      bit_time_q <= bit_time_d;
      // Line is re-registered so a popped frame reaches the pin one clock after the pop.
      serial_q   <= (state_q == StSend) ? frame_q[0] : 1'b1;
      overflow_q <= bus.write_i && full;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) mem_q[wr_ptr_q] <= {bus.parity_even_i, bus.parity_bit_i, bus.two_stop_bits_i,
                                  bus.data_i};
  end

  assign bus.full_o     = full;
  assign bus.empty_o    = empty;
  assign bus.level_o    = level_q;
  assign bus.overflow_o = overflow_q;
  assign bus.busy_o     = (state_q != StIdle) || !empty;
  assign bus.serial_o   = serial_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues hand-computed frames, a line monitor decodes.
module tb_uart_tx_fifo;
  localparam int unsigned Cdw = 16;
  localparam int unsigned Dw  = 8;
  localparam int unsigned Fdl = 4;

  logic clock_i = 1'b0;
  logic reset_i = 1'b1;

  uart_tx_fifo_if #(.CLOCK_DIVIDER_WIDTH(Cdw), .DATA_WIDTH(Dw), .FIFO_DEPTH_LOG2(Fdl)) bus ();

  uart_tx_fifo #(.CLOCK_DIVIDER_WIDTH(Cdw), .DATA_WIDTH(Dw), .FIFO_DEPTH_LOG2(Fdl)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [15:0] bits;   // bit i is the i-th bit on the line, start bit first
    int          len;
    int          t;
    bit          contig; // frame must start the cycle the previous one ended
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cycle    = 0;
  int   last_end = -1;
  bit   mon_busy = 1'b0;

  always @(posedge clock_i) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_frame(input logic [15:0] bits, input int len, input int t, input bit c);
    exp_t e;
    e.bits = bits; e.len = len; e.t = t; e.contig = c;
    exp_q.push_back(e);
  endtask

  task automatic push(input logic [7:0] d, input bit par, input bit even, input bit two);
    bus.data_i          = d;
    bus.parity_bit_i    = par;
    bus.parity_even_i   = even;
    bus.two_stop_bits_i = two;
    bus.write_i         = 1'b1;
    @(negedge clock_i);
    bus.write_i         = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((bus.busy_o || mon_busy || exp_q.size() != 0) && n < limit) begin
      @(negedge clock_i);
      n++;
    end
    check("idle_within_budget", 32'(n < limit), 32'd1);
  endtask

  // Line monitor: samples each bit mid-period and compares against the queued frame.
  initial begin : monitor
    forever begin
      @(negedge clock_i);
      if (!reset_i && bus.serial_o === 1'b0) begin
        exp_t        e;
        logic [15:0] got;
        int          o, detect;
        bit          aborted, known;
        mon_busy = 1'b1;
        got = '0; o = 0; aborted = 1'b0; detect = cycle;
        known = (exp_q.size() != 0);
        if (known) begin
          e = exp_q.pop_front();
        end else begin
          e.bits = '0; e.len = 10; e.t = 1; e.contig = 1'b0;
          checks++; errors++;
          $display("FAIL unexpected_frame: got start bit at cycle %0d expected none", cycle);
        end
        if (known && e.contig) check("frame_gap", 32'(detect), 32'(last_end));
        for (int i = 0; i < e.len; i++) begin
          int target;
          target = i * e.t + (e.t - 1) / 2;
          while (o < target && !aborted) begin
            @(negedge clock_i);
            o++;
            if (reset_i) aborted = 1'b1;
          end
          if (!aborted) got[i] = bus.serial_o;
        end
        while (o < e.len * e.t - 1 && !aborted) begin
          @(negedge clock_i);
          o++;
          if (reset_i) aborted = 1'b1;
        end
        if (known && !aborted) check("frame_bits", 32'(got), 32'(e.bits));
        last_end = detect + e.len * e.t;
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    bus.clock_divider_i = 16'd4;
    bus.data_i          = '0;
    bus.write_i         = 1'b0;
    bus.two_stop_bits_i = 1'b0;
    bus.parity_bit_i    = 1'b0;
    bus.parity_even_i   = 1'b0;
`ifdef UART_TX_FIFO_CTS_EN
    bus.cts_i           = 1'b1;
`endif
    repeat (3) @(negedge clock_i);
    check("rst_serial", 32'(bus.serial_o), 32'd1);
    check("rst_full", 32'(bus.full_o), 32'd0);
    check("rst_empty", 32'(bus.empty_o), 32'd1);
    check("rst_level", 32'(bus.level_o), 32'd0);
    check("rst_overflow", 32'(bus.overflow_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd1);

    // Fill the FIFO while the transmitter is held in its post-reset quiet period (48 clks).
    reset_i = 1'b0;
    push(8'h00, 1'b0, 1'b0, 1'b0);
    check("level_one", 32'(bus.level_o), 32'd1);
    for (int i = 1; i < 16; i++) push(8'(i), 1'b0, 1'b0, 1'b0);
    check("fill_level", 32'(bus.level_o), 32'd16);
    check("fill_full", 32'(bus.full_o), 32'd1);
    check("fill_empty", 32'(bus.empty_o), 32'd0);
    push(8'hEE, 1'b0, 1'b0, 1'b0);
    check("overflow_pulse", 32'(bus.overflow_o), 32'd1);
    check("overflow_level", 32'(bus.level_o), 32'd16);
    @(negedge clock_i);
    check("overflow_clear", 32'(bus.overflow_o), 32'd0);
    #2 reset_i = 1'b1;
    #1;
    check("async_rst_level", 32'(bus.level_o), 32'd0);
    check("async_rst_full", 32'(bus.full_o), 32'd0);
    check("async_rst_empty", 32'(bus.empty_o), 32'd1);
    repeat (2) @(negedge clock_i);

    // 0x55 8N1 at T=4, pushed together with reset release: 48 quiet clks, pop, then start bit.
    reset_i             = 1'b0;
    bus.data_i          = 8'h55;
    bus.write_i         = 1'b1;
    expect_frame(16'h02AA, 10, 4, 1'b0);
    n = 0;
    while (bus.serial_o === 1'b1 && n < 500) begin
      n++;
      @(negedge clock_i);
      bus.write_i = 1'b0;
    end
    check("release_high_clks", 32'(n), 32'd50);
    bus.clock_divider_i = 16'd9;
    wait_idle(200);
    check("t1_busy_drop", 32'(bus.busy_o), 32'd0);
    check("t1_line_idle", 32'(bus.serial_o), 32'd1);

    // 0x07 with even, odd, odd+2 stop, then 8N1, all back to back at T=2.
    bus.clock_divider_i = 16'd2;
    expect_frame(16'h060E, 11, 2, 1'b0);
    expect_frame(16'h040E, 11, 2, 1'b1);
    expect_frame(16'h0C0E, 12, 2, 1'b1);
    expect_frame(16'h020E, 10, 2, 1'b1);
    push(8'h07, 1'b1, 1'b1, 1'b0);
    push(8'h07, 1'b1, 1'b0, 1'b0);
    push(8'h07, 1'b1, 1'b0, 1'b1);
    push(8'h07, 1'b0, 1'b0, 1'b0);
    wait_idle(400);

    // Three 8N1 characters at T=3; second push coincides with the first pop.
    bus.clock_divider_i = 16'd3;
    expect_frame(16'h0202, 10, 3, 1'b0);
    expect_frame(16'h0204, 10, 3, 1'b1);
    expect_frame(16'h0206, 10, 3, 1'b1);
    push(8'h01, 1'b0, 1'b0, 1'b0);
    check("t4_level_a", 32'(bus.level_o), 32'd1);
    push(8'h02, 1'b0, 1'b0, 1'b0);
    check("t4_level_push_pop", 32'(bus.level_o), 32'd1);
    push(8'h03, 1'b0, 1'b0, 1'b0);
    check("t4_level_c", 32'(bus.level_o), 32'd2);
    wait_idle(400);
    check("t4_empty", 32'(bus.empty_o), 32'd1);

    // Divider 0 behaves as 1 clock per bit.
    bus.clock_divider_i = 16'd0;
    expect_frame(16'h0346, 10, 1, 1'b0);
    push(8'hA3, 1'b0, 1'b0, 1'b0);
    wait_idle(100);

    // Reset in the middle of a data bit abandons the frame and flushes the FIFO.
    bus.clock_divider_i = 16'd4;
    expect_frame(16'h03E0, 10, 4, 1'b0);
    push(8'hF0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (bus.serial_o === 1'b1 && n < 50) begin
      n++;
      @(negedge clock_i);
    end
    push(8'h11, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clock_i);
    check("t5_mid_data_low", 32'(bus.serial_o), 32'd0);
    check("t5_level_before", 32'(bus.level_o), 32'd1);
    #2 reset_i = 1'b1;
    #1;
    check("t5_line_high", 32'(bus.serial_o), 32'd1);
    check("t5_level_zero", 32'(bus.level_o), 32'd0);
    check("t5_busy", 32'(bus.busy_o), 32'd1);
    repeat (2) @(negedge clock_i);
    reset_i = 1'b0;
    n = 0;
    while (bus.busy_o === 1'b1 && n < 500) begin
      n++;
      @(negedge clock_i);
    end
    check("t5_quiet_clks", 32'(n), 32'd48);
    check("t5_no_frame_left", 32'(exp_q.size()), 32'd0);

`ifdef UART_TX_FIFO_CTS_EN
    // Clear-to-send low holds the character; raising it starts the frame through the synchroniser.
    bus.cts_i = 1'b0;
    repeat (3) @(negedge clock_i);
    bus.clock_divider_i = 16'd2;
    expect_frame(16'h034A, 10, 2, 1'b0);
    push(8'hA5, 1'b0, 1'b0, 1'b0);
    n = 0;
    repeat (20) begin
      @(negedge clock_i);
      if (bus.serial_o === 1'b1) n++;
    end
    check("cts_hold", 32'(n), 32'd20);
    bus.cts_i = 1'b1;
    n = 0;
    while (bus.serial_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clock_i);
    end
    check("cts_latency", 32'(n), 32'd4);
    wait_idle(100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
